// File: rtl/hazard_stall_ctrl_if.sv
// Hazard unit bundle: ID/EX/MEM hazard inputs in,
// pipeline enables, flush/bubble, timeout and perf counters out.
interface hazard_stall_ctrl_if;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_UsesRs;
  logic        ID_UsesRt;
  logic        EX_RegWrite;
  logic [1:0]  EX_RegSrc;
  logic [4:0]  EX_WriteReg;
  logic        EX_BranchTaken;
  logic        MEM_MemReq;
  logic        MEM_MemReady;
  logic        PC_Write;
  logic        IFID_Write;
  logic        IDEX_Write;
  logic        EXMEM_Write;
  logic        IFID_Flush;
  logic        IDEX_Bubble;
  logic        MEMWB_Bubble;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport master (
    output ID_rs, ID_rt, ID_UsesRs, ID_UsesRt,
    output EX_RegWrite, EX_RegSrc, EX_WriteReg,
    output EX_BranchTaken, MEM_MemReq, MEM_MemReady,
    input  PC_Write, IFID_Write, IDEX_Write,
    input  EXMEM_Write, IFID_Flush, IDEX_Bubble,
    input  MEMWB_Bubble, mem_timeout,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UsesRs, ID_UsesRt,
    input  EX_RegWrite, EX_RegSrc, EX_WriteReg,
    input  EX_BranchTaken, MEM_MemReq, MEM_MemReady,
    output PC_Write, IFID_Write, IDEX_Write,
    output EXMEM_Write, IFID_Flush, IDEX_Bubble,
    output MEMWB_Bubble, mem_timeout,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: memory wait > branch flush > load-use.
// Ports: clk, rst (async high), hz (slave bundle). Perf counters: HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int unsigned WAIT_MAX = 255
) (
  input logic          clk,
  input logic          rst,
  hazard_stall_ctrl_if.slave hz
);
  localparam logic [1:0]  REGSRC_DMEM = 2'b01;
  localparam logic [15:0] WAIT_LIM = 16'(WAIT_MAX);

  typedef enum logic {RUN, MEMWAIT} state_e;

  state_e      state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        tmo_q, tmo_d;

  logic mem_wait, load_use, rs_hit, rt_hit;
  logic ev_mem, ev_br, ev_lu;
  logic pc_we, ifid_we, idex_we, exmem_we;
  logic ifid_fl, idex_bub, memwb_bub;

  always_comb begin
    rs_hit = hz.ID_UsesRs &&
             (hz.EX_WriteReg == hz.ID_rs);
    rt_hit = hz.ID_UsesRt &&
             (hz.EX_WriteReg == hz.ID_rt);
    load_use = hz.EX_RegWrite &&
               (hz.EX_RegSrc == REGSRC_DMEM) &&
               (hz.EX_WriteReg != 5'd0) &&
               (rs_hit || rt_hit);
    mem_wait = hz.MEM_MemReq && !hz.MEM_MemReady;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // The cycle that enters MEMWAIT already counts as the first wait cycle.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      RUN: begin
        wcnt_d = '0;
        if (mem_wait) begin
          state_d = MEMWAIT;
          wcnt_d  = 16'd1;
        end
      end
      MEMWAIT: begin
        if (!mem_wait) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q != WAIT_LIM) begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
    tmo_d = tmo_q || (wcnt_d == WAIT_LIM);
  end

  // In MEMWAIT the stall holds until ready; the ready cycle runs free.
  always_comb begin
    ev_mem = (state_q == MEMWAIT) ? mem_wait
                                  : mem_wait;
    ev_br  = !ev_mem && hz.EX_BranchTaken;
    ev_lu  = !ev_mem && !ev_br && load_use;
    pc_we     = 1'b1;
    ifid_we   = 1'b1;
    idex_we   = 1'b1;
    exmem_we  = 1'b1;
    ifid_fl   = 1'b0;
    idex_bub  = 1'b0;
    memwb_bub = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        ev_mem: begin
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          idex_we   = 1'b0;
          exmem_we  = 1'b0;
          memwb_bub = 1'b1;
        end
        ev_br: begin
          ifid_fl  = 1'b1;
          idex_bub = 1'b1;
        end
        ev_lu: begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          idex_bub = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hz.PC_Write     = pc_we;
  assign hz.IFID_Write   = ifid_we;
  assign hz.IDEX_Write   = idex_we;
  assign hz.EXMEM_Write  = exmem_we;
  assign hz.IFID_Flush   = ifid_fl;
  assign hz.IDEX_Bubble  = idex_bub;
  assign hz.MEMWB_Bubble = memwb_bub;
  assign hz.mem_timeout  = tmo_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_we)  stall_q <= stall_q + 32'd1;
      if (ifid_fl) flush_q <= flush_q + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_count  = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl (WAIT_MAX=4).
// Directed vectors push expectations; a negedge monitor checks them.
module tb_hazard_stall_ctrl;
  localparam logic [1:0] ALU  = 2'b00;
  localparam logic [1:0] DMEM = 2'b01;

  logic clk;
  logic rst;

  hazard_stall_ctrl_if hz ();

  hazard_stall_ctrl #(.WAIT_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [3:0]  en;
    logic        fl;
    logic        bub;
    logic        mwb;
    logic        to;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;
  int vid    = 0;
  int acc_s  = 0;
  int acc_f  = 0;

  task automatic vec(
    input bit r,
    input logic [4:0] rs, input logic [4:0] rt,
    input bit ur, input bit ut,
    input bit exw, input logic [1:0] src,
    input logic [4:0] wr,
    input bit br, input bit req, input bit rdy,
    input logic [3:0] en,
    input bit fl, input bit bub, input bit mwb,
    input bit to
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    hz.ID_rs = rs;
    hz.ID_rt = rt;
    hz.ID_UsesRs = ur;
    hz.ID_UsesRt = ut;
    hz.EX_RegWrite = exw;
    hz.EX_RegSrc = src;
    hz.EX_WriteReg = wr;
    hz.EX_BranchTaken = br;
    hz.MEM_MemReq = req;
    hz.MEM_MemReady = rdy;
    if (r) begin
      acc_s = 0;
      acc_f = 0;
    end
    e.id  = vid;
    e.en  = en;
    e.fl  = fl;
    e.bub = bub;
    e.mwb = mwb;
    e.to  = to;
`ifdef HAZARD_PERF_CNT_EN
    e.sc = 32'(acc_s);
    e.fc = 32'(acc_f);
`else
    e.sc = '0;
    e.fc = '0;
`endif
    q.push_back(e);
    if (!r && !en[3]) acc_s++;
    if (!r && fl) acc_f++;
    vid++;
  endtask

  initial begin : monitor
    exp_t e;
    logic [3:0] en_a;
    logic [2:0] fb_a, fb_e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        en_a = {hz.PC_Write, hz.IFID_Write,
                hz.IDEX_Write, hz.EXMEM_Write};
        fb_a = {hz.IFID_Flush, hz.IDEX_Bubble,
                hz.MEMWB_Bubble};
        fb_e = {e.fl, e.bub, e.mwb};
        checks++;
        if (en_a !== e.en || fb_a !== fb_e) begin
          fails++;
          $display("FAIL ctrl v%0d: en=%b fb=%b want en=%b fb=%b",
                   e.id, en_a, fb_a, e.en, fb_e);
        end
        checks++;
        if (hz.mem_timeout !== e.to) begin
          fails++;
          $display("FAIL timeout v%0d: got %b want %b",
                   e.id, hz.mem_timeout, e.to);
        end
        checks++;
        if (hz.stall_cycles !== e.sc ||
            hz.flush_count !== e.fc) begin
          fails++;
          $display("FAIL counters v%0d: got %0d/%0d want %0d/%0d",
                   e.id, hz.stall_cycles, hz.flush_count,
                   e.sc, e.fc);
        end
      end
    end
  end

  initial begin : driver
    rst = 1'b1;
    hz.ID_rs = '0;
    hz.ID_rt = '0;
    hz.ID_UsesRs = 1'b0;
    hz.ID_UsesRt = 1'b0;
    hz.EX_RegWrite = 1'b0;
    hz.EX_RegSrc = ALU;
    hz.EX_WriteReg = '0;
    hz.EX_BranchTaken = 1'b0;
    hz.MEM_MemReq = 1'b0;
    hz.MEM_MemReady = 1'b0;
    //  r  rs rt ur ut ex src  wr br rq rd  en    fl bu mw to
    vec(1, 0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
    vec(0, 0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
    // load-use on rs, one stall then free
    vec(0, 8, 0, 1, 0, 1, DMEM, 8, 0, 0, 0, 4'h3, 0, 1, 0, 0);
    vec(0, 8, 0, 1, 0, 0, ALU, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
    // $0 load and ALU producer never stall
    vec(0, 0, 0, 1, 0, 1, DMEM, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
    vec(0, 8, 0, 1, 0, 1, ALU, 8, 0, 0, 0, 4'hF, 0, 0, 0, 0);
    // load-use on rt; unused rt ignored
    vec(0, 3, 9, 0, 1, 1, DMEM, 9, 0, 0, 0, 4'h3, 0, 1, 0, 0);
    vec(0, 3, 9, 1, 0, 1, DMEM, 9, 0, 0, 0, 4'hF, 0, 0, 0, 0);
    // branch beats load-use
    vec(0, 8, 0, 1, 0, 1, DMEM, 8, 1, 0, 0, 4'hF, 1, 1, 0, 0);
    // memory wait beats both, 3 cycles then ready
    vec(0, 8, 0, 1, 0, 1, DMEM, 8, 1, 1, 0, 4'h0, 0, 0, 1, 0);
    vec(0, 0, 0, 0, 0, 0, ALU, 0, 0, 1, 0, 4'h0, 0, 0, 1, 0);
    vec(0, 0, 0, 0, 0, 0, ALU, 0, 0, 1, 0, 4'h0, 0, 0, 1, 0);
    vec(0, 0, 0, 0, 0, 0, ALU, 0, 0, 1, 1, 4'hF, 0, 0, 0, 0);
    // 6-cycle wait: timeout visible after 4th
    for (int i = 0; i < 6; i++)
      vec(0, 0, 0, 0, 0, 0, ALU, 0, 0, 1, 0, 4'h0, 0, 0, 1,
          (i >= 4) ? 1'b1 : 1'b0);
    vec(0, 0, 0, 0, 0, 0, ALU, 0, 0, 1, 1, 4'hF, 0, 0, 0, 1);
    vec(0, 0, 0, 0, 0, 0, ALU, 0, 0, 1, 0, 4'h0, 0, 0, 1, 1);
    // reset mid-wait abandons the stall
    vec(1, 0, 0, 0, 0, 0, ALU, 0, 0, 1, 0, 4'hF, 0, 0, 0, 0);
    vec(0, 0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
    vec(0, 0, 0, 0, 0, 0, ALU, 0, 0, 1, 1, 4'hF, 0, 0, 0, 0);
    vec(0, 5, 0, 1, 0, 1, DMEM, 5, 0, 0, 0, 4'h3, 0, 1, 0, 0);
    vec(0, 0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
    vec(0, 0, 0, 0, 0, 0, ALU, 0, 1, 0, 0, 4'hF, 1, 1, 0, 0);
    vec(0, 0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end
endmodule
